// File: rtl/layer_ser_pkg.sv
// Shared types and helpers for the layer output serializer.
package layer_ser_pkg;

  typedef enum logic {S_IDLE, S_STREAM} ser_state_t;

  // Widest packed vector / word that slice_word can extract from.
  localparam int unsigned SLICE_VEC_W  = 4096;
  localparam int unsigned SLICE_WORD_W = 64;

  // Extract word i of width w from a packed vector (caller truncates to w).
  function automatic logic [SLICE_WORD_W-1:0] slice_word(
    input logic [SLICE_VEC_W-1:0] vec,
    input int unsigned            i,
    input int unsigned            w
  );
    return SLICE_WORD_W'(vec >> (i * w));
  endfunction

endpackage

// File: rtl/layer_argmax.sv
// Running signed argmax over each streamed vector; ties keep the lower index.
module layer_argmax #(
  parameter int unsigned NUM_NEURON = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  valid,
  output logic [IDX_WIDTH-1:0]  argmax_idx,
  output logic                  argmax_valid
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURON - 1);

  logic [DATA_WIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0]  best_q;
  logic                  take_c;
  logic [DATA_WIDTH-1:0] win_max_c;
  logic [IDX_WIDTH-1:0]  win_idx_c;

  // Index 0 restarts the tracker; later words win only when strictly greater.
  always_comb begin
    take_c    = (idx == '0) || ($signed(word) > $signed(max_q));
    win_max_c = take_c ? word : max_q;
    win_idx_c = take_c ? idx  : best_q;
  end

  // Track the running maximum and publish the winner after the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q        <= '0;
      best_q       <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= valid && (idx == LAST_IDX);
      if (valid) begin
        max_q  <= win_max_c;
        best_q <= win_idx_c;
        if (idx == LAST_IDX) begin
          argmax_idx <= win_idx_c;
        end
      end
    end
  end

endmodule

// File: rtl/layer_out_serializer.sv
// Collects the parallel neuron results of one layer and replays them as a
// dense serial stream (index 0 first) into the next layer. Double-buffered.
// Optional: define LAYER_ARGMAX_EN to add a signed argmax over each vector.
module layer_out_serializer
  import layer_ser_pkg::*;
#(
  parameter  int unsigned NUM_NEURON = 10,
  parameter  int unsigned DATA_WIDTH = 16,
  localparam int unsigned IDX_WIDTH  = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURON-1:0]            neuron_valid,
  output logic [DATA_WIDTH-1:0]            next_input,
  output logic                             next_input_valid,
  output logic                             busy,
  output logic                             overrun,
  output logic [IDX_WIDTH-1:0]             argmax_idx,
  output logic                             argmax_valid
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURON - 1);

  logic [DATA_WIDTH-1:0] cap_reg [NUM_NEURON];
  logic [DATA_WIDTH-1:0] cap_nxt [NUM_NEURON];
  logic [DATA_WIDTH-1:0] tx_buf  [NUM_NEURON];
  logic [NUM_NEURON-1:0] mask, mask_nxt;
  logic                  pending, pending_nxt;
  ser_state_t            state, state_nxt;
  logic [IDX_WIDTH-1:0]  idx, idx_nxt;
  logic [DATA_WIDTH-1:0] next_input_nxt;
  logic                  next_input_valid_nxt;
  logic                  overrun_nxt;
  logic                  busy_nxt;
  logic                  full_c;
  logic                  last_c;
  logic                  load_c;

  // Capture buffer as it will be after this edge, so a completing word is
  // visible to a same-edge reload of tx_buf.
  always_comb begin
    for (int unsigned i = 0; i < NUM_NEURON; i++) begin
      cap_nxt[i] = neuron_valid[i]
                 ? DATA_WIDTH'(slice_word(SLICE_VEC_W'(neuron_out), i, DATA_WIDTH))
                 : cap_reg[i];
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    full_c               = &(mask | neuron_valid);
    last_c               = (idx == LAST_IDX);
    load_c               = (full_c || pending) && ((state == S_IDLE) || last_c);

    state_nxt            = state;
    idx_nxt              = idx;
    next_input_nxt       = next_input;
    next_input_valid_nxt = 1'b0;
    mask_nxt             = full_c ? '0 : (mask | neuron_valid);
    overrun_nxt          = overrun | (|(neuron_valid & mask)) | (full_c & pending);
    pending_nxt          = pending;

    if (load_c) begin
      pending_nxt = 1'b0;
    end else if (full_c) begin
      pending_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (load_c) begin
          state_nxt            = S_STREAM;
          idx_nxt              = '0;
          next_input_nxt       = cap_nxt[0];
          next_input_valid_nxt = 1'b1;
        end
      end
      S_STREAM: begin
        if (!last_c) begin
          idx_nxt              = idx + IDX_WIDTH'(1);
          next_input_nxt       = tx_buf[idx_nxt];
          next_input_valid_nxt = 1'b1;
        end else if (load_c) begin
          idx_nxt              = '0;
          next_input_nxt       = cap_nxt[0];
          next_input_valid_nxt = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_STREAM) | pending_nxt;
  end

  // Control state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= '0;
      mask             <= '0;
      pending          <= 1'b0;
      next_input       <= '0;
      next_input_valid <= 1'b0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= state_nxt;
      idx              <= idx_nxt;
      mask             <= mask_nxt;
      pending          <= pending_nxt;
      next_input       <= next_input_nxt;
      next_input_valid <= next_input_valid_nxt;
      busy             <= busy_nxt;
      overrun          <= overrun_nxt;
    end
  end

  // Data buffers need no reset; mask and pending qualify their contents.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_NEURON; i++) begin
      cap_reg[i] <= cap_nxt[i];
      if (load_c) begin
        tx_buf[i] <= cap_nxt[i];
      end
    end
  end

`ifdef LAYER_ARGMAX_EN
  layer_argmax #(
    .NUM_NEURON (NUM_NEURON),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .idx          (idx),
    .word         (next_input),
    .valid        (next_input_valid),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
  );
`else
  assign argmax_idx   = '0;
  assign argmax_valid = 1'b0;
`endif

endmodule
